// File: rtl/universal_shift_register.sv
// ============================================================================
// universal_shift_register: parametrised shift/rotate/load register with a
// frame counter. Rotate modes exist only when USR_ROTATE_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_in_lsb,
  input  logic             ser_in_msb,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic             frame_done,
  output logic [CNT_W-1:0] shift_cnt
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
`ifdef USR_ROTATE_EN
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
`endif
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             is_shift;

  always_comb begin
    data_d   = data_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    is_shift = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: ;
        MODE_SHL: begin
          data_d   = {data_q[WIDTH-2:0], ser_in_lsb};
          is_shift = 1'b1;
        end
        MODE_SHR: begin
          data_d   = {ser_in_msb, data_q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_LOAD: begin
          data_d = par_in;
          cnt_d  = '0;
        end
`ifdef USR_ROTATE_EN
        MODE_ROL: begin
          data_d   = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
          is_shift = 1'b1;
        end
        MODE_ROR: begin
          data_d   = {data_q[0], data_q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
`endif
        MODE_ASR: begin
          data_d   = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
          is_shift = 1'b1;
        end
        MODE_CLR: begin
          data_d = '0;
          cnt_d  = '0;
        end
        default: ;
      endcase
      // The last shift of a frame wraps the count and raises the pulse.
      if (is_shift) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q           = data_q;
  assign ser_out_msb = data_q[WIDTH-1];
  assign ser_out_lsb = data_q[0];
  assign frame_done  = done_q;
  assign shift_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_register.sv
// ============================================================================
// tb_universal_shift_register: directed vector table plus reset/frame sequences
// for universal_shift_register at WIDTH=8. Honors USR_ROTATE_EN when defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_universal_shift_register;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] mode;
  logic       ser_in_lsb;
  logic       ser_in_msb;
  logic [7:0] par_in;
  logic [7:0] q;
  logic       ser_out_msb;
  logic       ser_out_lsb;
  logic       frame_done;
  logic [2:0] shift_cnt;

  int total = 0;
  int bad   = 0;

  universal_shift_register #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .ser_in_lsb  (ser_in_lsb),
    .ser_in_msb  (ser_in_msb),
    .par_in      (par_in),
    .q           (q),
    .ser_out_msb (ser_out_msb),
    .ser_out_lsb (ser_out_lsb),
    .frame_done  (frame_done),
    .shift_cnt   (shift_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic       sl;
    logic       sm;
    logic [7:0] par;
    logic [7:0] eq;
    logic [2:0] ecnt;
    logic       edone;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic e, input logic [2:0] m, input logic sl, input logic sm,
                     input logic [7:0] p, input logic [7:0] eq, input logic [2:0] ec,
                     input logic ed);
    vec_t v;
    v.en = e; v.mode = m; v.sl = sl; v.sm = sm; v.par = p;
    v.eq = eq; v.ecnt = ec; v.edone = ed;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, input logic [2:0] m, input logic sl, input logic sm,
                       input logic [7:0] p);
    en = e; mode = m; ser_in_lsb = sl; ser_in_msb = sm; par_in = p;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] mq;
  int         shifts;
  int         pulses;
  logic       cen;
  logic       csl;
  logic       edone;

  initial begin
    en = 1'b0; mode = 3'b000; ser_in_lsb = 1'b0; ser_in_msb = 1'b0; par_in = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_q", q, 8'h00);
    chk("reset_cnt", shift_cnt, 3'd0);
    chk("reset_done", frame_done, 1'b0);
    #9 rst_n = 1'b1;

    // Scenario 1: serial shift-in of 1,0,1,0,1,1,0,1
    add(1, 3'b001, 1, 0, 8'h00, 8'h01, 3'd1, 0);
    add(1, 3'b001, 0, 0, 8'h00, 8'h02, 3'd2, 0);
    add(1, 3'b001, 1, 0, 8'h00, 8'h05, 3'd3, 0);
    add(1, 3'b001, 0, 0, 8'h00, 8'h0A, 3'd4, 0);
    add(1, 3'b001, 1, 0, 8'h00, 8'h15, 3'd5, 0);
    add(1, 3'b001, 1, 0, 8'h00, 8'h2B, 3'd6, 0);
    add(1, 3'b001, 0, 0, 8'h00, 8'h56, 3'd7, 0);
    add(1, 3'b001, 1, 0, 8'h00, 8'hAD, 3'd0, 1);
    add(1, 3'b000, 0, 0, 8'h00, 8'hAD, 3'd0, 0);
    // Scenario 2: load, logical shift right, reload aborts frame
    add(1, 3'b011, 0, 0, 8'h96, 8'h96, 3'd0, 0);
    add(1, 3'b010, 0, 0, 8'h00, 8'h4B, 3'd1, 0);
    add(1, 3'b010, 0, 0, 8'h00, 8'h25, 3'd2, 0);
    add(1, 3'b011, 0, 0, 8'h96, 8'h96, 3'd0, 0);
    // Scenario 3: arithmetic shift right, ser_in_msb ignored
    add(1, 3'b110, 0, 0, 8'h00, 8'hCB, 3'd1, 0);
    add(1, 3'b011, 0, 0, 8'h25, 8'h25, 3'd0, 0);
    add(1, 3'b110, 0, 1, 8'h00, 8'h12, 3'd1, 0);
    add(1, 3'b010, 0, 1, 8'h00, 8'h89, 3'd2, 0);
    add(0, 3'b001, 1, 1, 8'h00, 8'h89, 3'd2, 0);
    add(1, 3'b111, 1, 1, 8'hFF, 8'h00, 3'd0, 0);
    // Scenario 4: rotate modes
    add(1, 3'b011, 0, 0, 8'h81, 8'h81, 3'd0, 0);
`ifdef USR_ROTATE_EN
    add(1, 3'b100, 0, 0, 8'h00, 8'h03, 3'd1, 0);
    add(1, 3'b101, 0, 0, 8'h00, 8'h81, 3'd2, 0);
    add(1, 3'b101, 0, 0, 8'h00, 8'hC0, 3'd3, 0);
`else
    add(1, 3'b100, 1, 1, 8'h00, 8'h81, 3'd0, 0);
    add(1, 3'b101, 1, 1, 8'h00, 8'h81, 3'd0, 0);
    add(1, 3'b101, 1, 1, 8'h00, 8'h81, 3'd0, 0);
`endif

    @(negedge clk);
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].en, vt[i].mode, vt[i].sl, vt[i].sm, vt[i].par);
      chk($sformatf("v%0d_q", i), q, vt[i].eq);
      chk($sformatf("v%0d_cnt", i), shift_cnt, vt[i].ecnt);
      chk($sformatf("v%0d_done", i), frame_done, vt[i].edone);
      chk($sformatf("v%0d_smsb", i), ser_out_msb, vt[i].eq[7]);
      chk($sformatf("v%0d_slsb", i), ser_out_lsb, vt[i].eq[0]);
    end

    // Scenario 5: asynchronous reset mid-frame
    drive(1, 3'b111, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) drive(1, 3'b001, 1, 0, 8'h00);
    chk("s5_pre_q", q, 8'h07);
    chk("s5_pre_cnt", shift_cnt, 3'd3);
    #3 rst_n = 1'b0;
    #1;
    chk("s5_rst_q", q, 8'h00);
    chk("s5_rst_cnt", shift_cnt, 3'd0);
    #1 rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1, 3'b001, 1, 0, 8'h00);
      chk($sformatf("s5_done%0d", i), frame_done, (i == 8) ? 1'b1 : 1'b0);
    end
    chk("s5_q", q, 8'hFF);

    // Scenario 6: 16 left shifts with en low for two cycles midway
    drive(1, 3'b111, 0, 0, 8'h00);
    mq = 8'h00; shifts = 0; pulses = 0;
    for (int c = 0; c < 18; c++) begin
      cen = !(c == 5 || c == 6);
      csl = (c % 3 == 0);
      edone = 1'b0;
      if (cen) begin
        mq = {mq[6:0], csl};
        shifts++;
        edone = (shifts % 8 == 0);
      end
      drive(cen, 3'b001, csl, 0, 8'h00);
      chk($sformatf("s6_q%0d", c), q, mq);
      chk($sformatf("s6_done%0d", c), frame_done, edone);
      if (frame_done) pulses++;
    end
    chk("s6_pulses", pulses, 2);
    chk("s6_cnt", shift_cnt, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
